// File: rtl/bimodal_reference_predictor.sv
// bimodal_reference_predictor
//   Golden branch-direction reference: static backward-taken/forward-not-taken
//   (mode 0) or a bimodal table of saturating counters indexed by low PC bits
//   (mode 1). The table trains on every resolved branch regardless of mode,
//   and a saturating counter tallies resolved mispredictions.
//
//   Request/response semantics: there is no back-pressure. A request is
//   accepted on every rising edge where predict_valid=1, and prediction /
//   prediction_valid present the answer for exactly the following cycle.
//   An update is applied on every rising edge where update_valid=1.
//   A prediction always reads the counter as it stood before any update on
//   the same edge (read-before-write).
module bimodal_reference_predictor #(
  parameter int PC_WIDTH   = 10,
  parameter int INDEX_BITS = 6,
  parameter int CTR_BITS   = 2,
  parameter int STAT_BITS  = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 mode,
  input  logic                 predict_valid,
  input  logic [PC_WIDTH-1:0]  predict_pc,
  input  logic [PC_WIDTH-1:0]  predict_target,
  output logic                 prediction,
  output logic                 prediction_valid,
  input  logic                 update_valid,
  input  logic [PC_WIDTH-1:0]  update_pc,
  input  logic                 update_taken,
  input  logic                 update_predicted,
  output logic [STAT_BITS-1:0] mispredict_count
);

  localparam int DEPTH = 1 << INDEX_BITS;
  // Weakly not-taken: MSB clear, all lower bits set (0 when CTR_BITS is 1).
  localparam logic [CTR_BITS-1:0]  CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0]  CTR_MAX  = {CTR_BITS{1'b1}};
  localparam logic [STAT_BITS-1:0] STAT_MAX = {STAT_BITS{1'b1}};

  logic [CTR_BITS-1:0]  table_q [DEPTH];
  logic [CTR_BITS-1:0]  table_d [DEPTH];
  logic                 prediction_q;
  logic                 prediction_d;
  logic                 prediction_valid_q;
  logic                 prediction_valid_d;
  logic [STAT_BITS-1:0] mispredict_count_q;
  logic [STAT_BITS-1:0] mispredict_count_d;

  logic [INDEX_BITS-1:0] predict_idx;
  logic [INDEX_BITS-1:0] update_idx;
  logic [CTR_BITS-1:0]   predict_ctr;
  logic [CTR_BITS-1:0]   update_ctr;

  // Index is the low PC bits; the cast zero-fills when the index is wider
  // than the PC.
  assign predict_idx = INDEX_BITS'(predict_pc);
  assign update_idx  = INDEX_BITS'(update_pc);
  assign predict_ctr = table_q[predict_idx];
  assign update_ctr  = table_q[update_idx];

  // Next prediction: hold the last answer when no request is presented.
  always_comb begin
    prediction_d       = prediction_q;
    prediction_valid_d = predict_valid;
    if (predict_valid) begin
      if (mode) begin
        prediction_d = predict_ctr[CTR_BITS-1];
      end else begin
        // Equal target counts as a backward branch.
        prediction_d = (predict_target <= predict_pc);
      end
    end
  end

  // Next table contents: saturating increment/decrement of the updated entry.
  always_comb begin
    table_d = table_q;
    if (update_valid) begin
      if (update_taken) begin
        if (update_ctr != CTR_MAX) begin
          table_d[update_idx] = update_ctr + CTR_BITS'(1);
        end
      end else begin
        if (update_ctr != '0) begin
          table_d[update_idx] = update_ctr - CTR_BITS'(1);
        end
      end
    end
  end

  // Next misprediction count: saturates, never wraps.
  always_comb begin
    mispredict_count_d = mispredict_count_q;
    if (update_valid && (update_taken != update_predicted) &&
        (mispredict_count_q != STAT_MAX)) begin
      mispredict_count_d = mispredict_count_q + STAT_BITS'(1);
    end
  end

  // Counter table register with asynchronous clear to weakly not-taken.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        table_q[i] <= CTR_INIT;
      end
    end else begin
      table_q <= table_d;
    end
  end

  // Output and statistics registers with asynchronous clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prediction_q       <= 1'b0;
      prediction_valid_q <= 1'b0;
      mispredict_count_q <= '0;
    end else begin
      prediction_q       <= prediction_d;
      prediction_valid_q <= prediction_valid_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign prediction       = prediction_q;
  assign prediction_valid = prediction_valid_q;
  assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_bimodal_reference_predictor.sv
// tb_bimodal_reference_predictor
//   Drives two predictor instances (default statistics width and a 2-bit
//   statistics width) with identical stimulus and compares both against a
//   behavioural model: integer counters per table slot, clamped arithmetic,
//   and an expected-prediction queue.
module tb_bimodal_reference_predictor;

  localparam int PC_WIDTH     = 10;
  localparam int INDEX_BITS   = 6;
  localparam int CTR_BITS     = 2;
  localparam int STAT_BITS    = 16;
  localparam int STAT_BITS_S  = 2;
  localparam int DEPTH        = 1 << INDEX_BITS;
  localparam int CTR_LIMIT    = (1 << CTR_BITS) - 1;
  localparam int CTR_WEAK_NT  = (1 << (CTR_BITS - 1)) - 1;
  localparam int STAT_LIMIT   = (1 << STAT_BITS) - 1;
  localparam int STAT_LIMIT_S = (1 << STAT_BITS_S) - 1;

  // ---------------- clock / reset block ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic                   mode = 1'b0;
  logic                   predict_valid = 1'b0;
  logic [PC_WIDTH-1:0]    predict_pc = '0;
  logic [PC_WIDTH-1:0]    predict_target = '0;
  logic                   update_valid = 1'b0;
  logic [PC_WIDTH-1:0]    update_pc = '0;
  logic                   update_taken = 1'b0;
  logic                   update_predicted = 1'b0;

  logic                   prediction;
  logic                   prediction_valid;
  logic [STAT_BITS-1:0]   mispredict_count;
  logic                   prediction_s;
  logic                   prediction_valid_s;
  logic [STAT_BITS_S-1:0] mispredict_count_s;

  bimodal_reference_predictor #(
    .PC_WIDTH(PC_WIDTH), .INDEX_BITS(INDEX_BITS),
    .CTR_BITS(CTR_BITS), .STAT_BITS(STAT_BITS)
  ) dut (
    .clock(clock), .reset(reset), .mode(mode),
    .predict_valid(predict_valid), .predict_pc(predict_pc),
    .predict_target(predict_target), .prediction(prediction),
    .prediction_valid(prediction_valid), .update_valid(update_valid),
    .update_pc(update_pc), .update_taken(update_taken),
    .update_predicted(update_predicted), .mispredict_count(mispredict_count)
  );

  bimodal_reference_predictor #(
    .PC_WIDTH(PC_WIDTH), .INDEX_BITS(INDEX_BITS),
    .CTR_BITS(CTR_BITS), .STAT_BITS(STAT_BITS_S)
  ) dut_s (
    .clock(clock), .reset(reset), .mode(mode),
    .predict_valid(predict_valid), .predict_pc(predict_pc),
    .predict_target(predict_target), .prediction(prediction_s),
    .prediction_valid(prediction_valid_s), .update_valid(update_valid),
    .update_pc(update_pc), .update_taken(update_taken),
    .update_predicted(update_predicted), .mispredict_count(mispredict_count_s)
  );

  // ---------------- scoreboard / model state ----------------
  int         n_checks = 0;
  int         n_errors = 0;
  int         model_ctr [DEPTH];
  int         model_cnt;
  int         model_cnt_s;
  logic       exp_pred;
  logic       exp_pv;
  logic [0:0] exp_q [$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) model_ctr[i] = CTR_WEAK_NT;
    model_cnt   = 0;
    model_cnt_s = 0;
    exp_pred    = 1'b0;
    exp_pv      = 1'b0;
    exp_q.delete();
  endtask

  // Advance one edge with the currently driven inputs, then compare.
  task automatic tick();
    int pi;
    int ui;
    // The prediction is formed from the table before this edge's update.
    if (predict_valid) begin
      pi = int'(predict_pc) % DEPTH;
      if (mode) exp_pred = (model_ctr[pi] > CTR_LIMIT / 2);
      else      exp_pred = (int'(predict_target) <= int'(predict_pc));
      exp_q.push_back(exp_pred);
    end
    exp_pv = predict_valid;
    if (update_valid) begin
      ui = int'(update_pc) % DEPTH;
      if (update_taken) model_ctr[ui] = (model_ctr[ui] + 1 > CTR_LIMIT) ? CTR_LIMIT : model_ctr[ui] + 1;
      else              model_ctr[ui] = (model_ctr[ui] - 1 < 0) ? 0 : model_ctr[ui] - 1;
      if (update_taken != update_predicted) begin
        if (model_cnt < STAT_LIMIT)     model_cnt++;
        if (model_cnt_s < STAT_LIMIT_S) model_cnt_s++;
      end
    end
    @(posedge clock);
    #1;
    check_eq("pred_valid", prediction_valid, exp_pv);
    if (exp_q.size() > 0) check_eq("pred", prediction, exp_q.pop_front());
    else                  check_eq("pred_hold", prediction, exp_pred);
    check_eq("pred_s", prediction_s, exp_pred);
    check_eq("count", mispredict_count, model_cnt);
    check_eq("count_s", mispredict_count_s, model_cnt_s);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic m, input logic pv, input logic [PC_WIDTH-1:0] ppc,
                       input logic [PC_WIDTH-1:0] ptgt, input logic uv,
                       input logic [PC_WIDTH-1:0] upc, input logic ut, input logic up);
    mode             = m;
    predict_valid    = pv;
    predict_pc       = ppc;
    predict_target   = ptgt;
    update_valid     = uv;
    update_pc        = upc;
    update_taken     = ut;
    update_predicted = up;
    tick();
    predict_valid = 1'b0;
    update_valid  = 1'b0;
  endtask

  task automatic do_predict(input logic m, input logic [PC_WIDTH-1:0] pc,
                            input logic [PC_WIDTH-1:0] tgt);
    drive(m, 1'b1, pc, tgt, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic do_update(input logic [PC_WIDTH-1:0] pc, input logic taken,
                           input logic predicted);
    drive(1'b1, 1'b0, '0, '0, 1'b1, pc, taken, predicted);
  endtask

  // Asynchronous reset pulse; outputs must clear before any clock edge.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check_eq("rst_pred", prediction, 0);
    check_eq("rst_pvalid", prediction_valid, 0);
    check_eq("rst_count", mispredict_count, 0);
    check_eq("rst_count_s", mispredict_count_s, 0);
    @(negedge clock);
    reset = 1'b0;
  endtask

  int sat_seq [5] = '{1, 2, 3, 3, 3};

  // ---------------- stimulus ----------------
  initial begin
    logic [PC_WIDTH-1:0] rpc;
    logic [PC_WIDTH-1:0] rupc;
    #2;
    do_reset();

    // Reset defaults
    do_predict(1'b1, 10'h005, 10'h000);
    check_eq("dflt_pred", prediction, 0);
    check_eq("dflt_pvalid", prediction_valid, 1);
    check_eq("dflt_count", mispredict_count, 0);
    drive(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
    check_eq("idle_pvalid", prediction_valid, 0);

    // Static BTFN
    do_predict(1'b0, 10'h100, 10'h0F0);
    check_eq("btfn_back", prediction, 1);
    do_predict(1'b0, 10'h100, 10'h100);
    check_eq("btfn_equal", prediction, 1);
    do_predict(1'b0, 10'h100, 10'h110);
    check_eq("btfn_fwd", prediction, 0);

    // Saturation up and down
    repeat (3) do_update(10'h003, 1'b1, 1'b1);
    do_predict(1'b1, 10'h003, '0);
    check_eq("sat_hi", prediction, 1);
    do_update(10'h003, 1'b0, 1'b0);
    do_predict(1'b1, 10'h003, '0);
    check_eq("strong_to_weak", prediction, 1);
    repeat (5) do_update(10'h003, 1'b0, 1'b0);
    do_predict(1'b1, 10'h003, '0);
    check_eq("sat_lo", prediction, 0);

    // Aliasing through the low index bits
    repeat (2) do_update(10'h041, 1'b1, 1'b1);
    do_predict(1'b1, 10'h001, '0);
    check_eq("alias", prediction, 1);

    // Same-edge predict and update: read-before-write
    drive(1'b1, 1'b1, 10'h002, '0, 1'b1, 10'h002, 1'b1, 1'b1);
    check_eq("rbw_old", prediction, 0);
    do_predict(1'b1, 10'h002, '0);
    check_eq("rbw_new", prediction, 1);

    // Misprediction counter saturation on the 2-bit instance
    do_reset();
    for (int i = 0; i < 5; i++) begin
      do_update(10'h010, 1'b1, 1'b0);
      check_eq("stat_sat_s", mispredict_count_s, sat_seq[i]);
      check_eq("stat_wide", mispredict_count, i + 1);
    end
    do_update(10'h010, 1'b1, 1'b1);
    check_eq("stat_hold_s", mispredict_count_s, 3);
    check_eq("stat_hold", mispredict_count, 5);

    // Asynchronous reset between edges while trained
    repeat (3) do_update(10'h003, 1'b1, 1'b1);
    do_predict(1'b1, 10'h003, '0);
    check_eq("pre_rst_pred", prediction, 1);
    #3;
    do_reset();
    do_predict(1'b1, 10'h003, '0);
    check_eq("post_rst_pred", prediction, 0);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rpc  = PC_WIDTH'($urandom_range(0, 1023));
      rupc = PC_WIDTH'($urandom_range(0, 1023));
      if ($urandom_range(0, 1) == 1) rpc  = PC_WIDTH'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) rupc = PC_WIDTH'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) rupc = rpc;
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0), rpc,
            PC_WIDTH'($urandom_range(0, 1023)), 1'($urandom_range(0, 1)), rupc,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
